// File: rtl/riscv_csr_pkg.sv
// Shared definitions for the machine-mode trap/CSR unit: CSR indices,
// mstatus bit positions, Zicsr op encodings and the redirect FSM states.
package riscv_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int IRQ_CAUSE_BASE = 16;
    localparam int IRQ_IDX_W      = 4;

    typedef enum logic [1:0] {
        CSR_OP_READ = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } trap_state_e;

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder for the interrupt pending vector; the lowest
// set index wins.
module irq_priority_enc
    import riscv_csr_pkg::*;
#(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]   req,
    output logic                 valid,
    output logic [IRQ_IDX_W-1:0] index,
    output logic [NUM_IRQ-1:0]   onehot
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        valid  = |req;
        index  = '0;
        onehot = '0;
        // Walk from the top down so the lowest requesting source is written last.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                index     = IRQ_IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_trap_csr.sv
// Machine-mode trap and CSR unit: prioritised level interrupts, Zicsr
// accesses, mret, and one-cycle pc redirects to the EXE stage.
module riscv_trap_csr
    import riscv_csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              NUM_IRQ     = 4,
    parameter logic [XLEN-1:0] RESET_MTVEC = '0,
    parameter bit              RESET_MIE   = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_req,
    output logic [NUM_IRQ-1:0] irq_ack,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               csr_en,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               csr_illegal,
    input  logic               mret,
    output logic               redirect,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               redirect_is_trap
);

    trap_state_e state_q, state_d;

    logic                 mstatus_mie_q, mstatus_mpie_q;
    logic [NUM_IRQ-1:0]   mie_q, mip_q, pend;
    logic [XLEN-1:0]      mtvec_q, mepc_q, mcause_q, mscratch_q;

    csr_op_e              op;
    logic                 addr_legal;
    logic                 enc_valid;
    logic [IRQ_IDX_W-1:0] enc_index;
    logic [NUM_IRQ-1:0]   enc_onehot;
    logic                 trap_take, mret_take, csr_we;
    logic [XLEN-1:0]      mstatus_val, new_val;
    logic [XLEN-1:0]      cause_num, trap_base, trap_target;

    assign op   = csr_op_e'(csr_op);
    assign pend = mip_q & mie_q;

    irq_priority_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req    (pend),
        .valid  (enc_valid),
        .index  (enc_index),
        .onehot (enc_onehot)
    );

    always_comb begin
        mstatus_val                                = '0;
        mstatus_val[MSTATUS_MIE]                   = mstatus_mie_q;
        mstatus_val[MSTATUS_MPIE]                  = mstatus_mpie_q;
        mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        csr_rdata  = '0;
        addr_legal = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:  csr_rdata = mstatus_val;
            CSR_MIE:      csr_rdata = XLEN'(mie_q) << IRQ_CAUSE_BASE;
            CSR_MIP:      csr_rdata = XLEN'(mip_q) << IRQ_CAUSE_BASE;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            default:      addr_legal = 1'b0;
        endcase
    end

    assign csr_illegal = csr_en & ~addr_legal;

    always_comb begin
        case (op)
            CSR_OP_RW: new_val = csr_wdata;
            CSR_OP_RS: new_val = csr_rdata | csr_wdata;
            CSR_OP_RC: new_val = csr_rdata & ~csr_wdata;
            default:   new_val = csr_rdata;
        endcase
    end

    // Vectored mode jumps to base + 4*cause; direct mode always to base.
    assign cause_num   = XLEN'(IRQ_CAUSE_BASE) + XLEN'(enc_index);
    assign trap_base   = mtvec_q & ~XLEN'(3);
    assign trap_target = mtvec_q[0] ? trap_base + (cause_num << 2) : trap_base;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (trap_take || mret_take) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // FSM: action decode; trap beats mret beats a CSR write.
    always_comb begin
        trap_take = (state_q == ST_RUN) && mstatus_mie_q && enc_valid;
        mret_take = (state_q == ST_RUN) && mret && !trap_take;
        csr_we    = (state_q == ST_RUN) && !trap_take && !mret && csr_en
                    && (op != CSR_OP_READ) && addr_legal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie_q    <= RESET_MIE;
            mstatus_mpie_q   <= 1'b0;
            mie_q            <= '1;
            mip_q            <= '0;
            mtvec_q          <= RESET_MTVEC & ~XLEN'(2);
            mepc_q           <= '0;
            mcause_q         <= '0;
            mscratch_q       <= '0;
            irq_ack          <= '0;
            redirect         <= 1'b0;
            redirect_pc      <= '0;
            redirect_is_trap <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            mip_q            <= irq_req;
            irq_ack          <= '0;
            redirect         <= 1'b0;
            redirect_is_trap <= 1'b0;
            if (trap_take) begin
                mepc_q           <= pc_in & ~XLEN'(3);
                mcause_q         <= cause_num | (XLEN'(1) << (XLEN - 1));
                mstatus_mpie_q   <= mstatus_mie_q;
                mstatus_mie_q    <= 1'b0;
                irq_ack          <= enc_onehot;
                redirect         <= 1'b1;
                redirect_is_trap <= 1'b1;
                redirect_pc      <= trap_target;
            end else if (mret_take) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
                redirect       <= 1'b1;
                redirect_pc    <= mepc_q;
            end else if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie_q  <= new_val[MSTATUS_MIE];
                        mstatus_mpie_q <= new_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_q      <= NUM_IRQ'(new_val >> IRQ_CAUSE_BASE);
                    CSR_MTVEC:    mtvec_q    <= new_val & ~XLEN'(2);
                    CSR_MEPC:     mepc_q     <= new_val & ~XLEN'(3);
                    CSR_MCAUSE:   mcause_q   <= new_val;
                    CSR_MSCRATCH: mscratch_q <= new_val;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_riscv_trap_csr.sv
// Directed bench for riscv_trap_csr: expected values are queued as stimulus
// is applied and popped as the DUT's responses are sampled.
module tb_riscv_trap_csr;
    import riscv_csr_pkg::*;

    localparam int XLEN    = 64;
    localparam int NUM_IRQ = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_IRQ-1:0] irq_req;
    logic [NUM_IRQ-1:0] irq_ack;
    logic [XLEN-1:0]    pc_in;
    logic               csr_en;
    logic [1:0]         csr_op;
    logic [11:0]        csr_addr;
    logic [XLEN-1:0]    csr_wdata;
    logic [XLEN-1:0]    csr_rdata;
    logic               csr_illegal;
    logic               mret;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic               redirect_is_trap;

    always #5 clk = ~clk;

    riscv_trap_csr #(
        .XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .RESET_MTVEC(64'h0), .RESET_MIE(1'b1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .irq_req          (irq_req),
        .irq_ack          (irq_ack),
        .pc_in            (pc_in),
        .csr_en           (csr_en),
        .csr_op           (csr_op),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .csr_rdata        (csr_rdata),
        .csr_illegal      (csr_illegal),
        .mret             (mret),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .redirect_is_trap (redirect_is_trap)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input logic [11:0] a);
        csr_addr = a;
        #1;
        pop_check(csr_rdata);
    endtask

    task automatic csr_do(input csr_op_e o, input logic [11:0] a, input logic [63:0] d);
        csr_en    = 1'b1;
        csr_op    = o;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_en    = 1'b0;
        csr_op    = CSR_OP_READ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw;
        reset = 1'b1; irq_req = '0; pc_in = '0; csr_en = 1'b0; csr_op = CSR_OP_READ;
        csr_addr = '0; csr_wdata = '0; mret = 1'b0;

        // Reset state
        push("rst_redirect", 64'd0);
        push("rst_ack", 64'd0);
        #3;
        pop_check(64'(redirect));
        pop_check(64'(irq_ack));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();
        push("rst_mstatus", 64'h1808);
        push("rst_mie", 64'hF0000);
        push("rst_mtvec", 64'h0);
        push("rst_mip", 64'h0);
        rd_check(CSR_MSTATUS);
        rd_check(CSR_MIE);
        rd_check(CSR_MTVEC);
        rd_check(CSR_MIP);
        tick();

        // Direct-mode trap from source 1, two-cycle latency
        pc_in   = 64'h8000_0012;
        irq_req = 4'b0010;
        push("lat_n1_redirect", 64'd0);
        push("trap_redirect", 64'd1);
        push("trap_is_trap", 64'd1);
        push("trap_pc", 64'h0);
        push("trap_ack", 64'h2);
        push("trap_mepc", 64'h8000_0010);
        push("trap_mcause", 64'h8000_0000_0000_0011);
        push("trap_mstatus", 64'h1880);
        push("trap_mip", 64'h20000);
        tick();
        pop_check(64'(redirect));
        tick();
        pop_check(64'(redirect));
        pop_check(64'(redirect_is_trap));
        pop_check(redirect_pc);
        pop_check(64'(irq_ack));
        rd_check(CSR_MEPC);
        rd_check(CSR_MCAUSE);
        rd_check(CSR_MSTATUS);
        rd_check(CSR_MIP);
        tick();
        push("ack_one_cycle", 64'd0);
        push("redirect_one_cycle", 64'd0);
        pop_check(64'(irq_ack));
        pop_check(64'(redirect));
        for (int i = 0; i < 3; i++) begin
            push("held_irq_no_retake", 64'd0);
            tick();
            pop_check(64'(redirect));
        end

        // mret, then an mret held into the FLUSH cycle is ignored
        irq_req = '0;
        tick();
        tick();
        mret = 1'b1;
        push("mret_redirect", 64'd1);
        push("mret_is_trap", 64'd0);
        push("mret_pc", 64'h8000_0010);
        push("flush_mret_ignored", 64'd0);
        push("mret_mstatus", 64'h1888);
        tick();
        pop_check(64'(redirect));
        pop_check(64'(redirect_is_trap));
        pop_check(redirect_pc);
        tick();
        mret = 1'b0;
        pop_check(64'(redirect));
        rd_check(CSR_MSTATUS);
        tick();

        // Vectored mtvec; bit 1 of the written value is dropped
        csr_do(CSR_OP_RW, CSR_MTVEC, 64'h1003);
        push("mtvec_bit1_clear", 64'h1001);
        rd_check(CSR_MTVEC);
        tick();
        pc_in   = 64'h4006;
        irq_req = 4'b1010;
        push("vec_redirect", 64'd1);
        push("vec_pc", 64'h1044);
        push("vec_ack", 64'h2);
        push("vec_mepc", 64'h4004);
        tick();
        tick();
        pop_check(64'(redirect));
        pop_check(redirect_pc);
        pop_check(64'(irq_ack));
        rd_check(CSR_MEPC);
        irq_req = '0;
        tick();
        tick();
        mret = 1'b1;
        push("mret2_pc", 64'h4004);
        tick();
        mret = 1'b0;
        pop_check(redirect_pc);
        tick();

        // Masked source never traps
        csr_do(CSR_OP_RC, CSR_MIE, 64'h20000);
        push("mie_rc", 64'hD0000);
        rd_check(CSR_MIE);
        irq_req = 4'b0010;
        saw = 1'b0;
        push("masked_no_trap", 64'd0);
        push("masked_mip", 64'h20000);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (redirect) saw = 1'b1;
        end
        pop_check(64'(saw));
        rd_check(CSR_MIP);
        irq_req = '0;
        tick();
        tick();

        // Illegal address and read-only mip
        csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = 12'h7C0; csr_wdata = '1;
        push("illegal_flag", 64'd1);
        #1;
        pop_check(64'(csr_illegal));
        tick();
        csr_en = 1'b0;
        push("illegal_mstatus", 64'h1888);
        push("illegal_mie", 64'hD0000);
        push("illegal_mscratch", 64'h0);
        rd_check(CSR_MSTATUS);
        rd_check(CSR_MIE);
        rd_check(CSR_MSCRATCH);
        tick();
        csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MIP; csr_wdata = '1;
        push("mip_write_legal", 64'd0);
        #1;
        pop_check(64'(csr_illegal));
        tick();
        csr_en = 1'b0;
        push("mip_write_ignored", 64'h0);
        rd_check(CSR_MIP);
        tick();

        // RW/RS/RC on mscratch, mepc low bits
        csr_do(CSR_OP_RW, CSR_MSCRATCH, 64'hDEAD_BEEF_0123_4567);
        csr_do(CSR_OP_RS, CSR_MSCRATCH, 64'hF0);
        push("mscratch_rs", 64'hDEAD_BEEF_0123_45F7);
        rd_check(CSR_MSCRATCH);
        tick();
        csr_do(CSR_OP_RC, CSR_MSCRATCH, 64'hDEAD_0000_0000_0007);
        csr_do(CSR_OP_RW, CSR_MEPC, 64'h1237);
        push("mscratch_rc", 64'h0000_BEEF_0123_45F0);
        push("mepc_align", 64'h1234);
        rd_check(CSR_MSCRATCH);
        rd_check(CSR_MEPC);
        tick();

        // Trap wins over a same-cycle mstatus write; reset kills the redirect
        csr_do(CSR_OP_RS, CSR_MIE, 64'h20000);
        pc_in   = 64'h9000;
        irq_req = 4'b0001;
        push("coll_redirect", 64'd1);
        push("coll_pc", 64'h1040);
        push("coll_ack", 64'h1);
        push("coll_mstatus", 64'h1880);
        push("coll_mepc", 64'h9000);
        tick();
        csr_en = 1'b1; csr_op = CSR_OP_RW; csr_addr = CSR_MSTATUS; csr_wdata = '0;
        tick();
        csr_en = 1'b0;
        pop_check(64'(redirect));
        pop_check(redirect_pc);
        pop_check(64'(irq_ack));
        rd_check(CSR_MSTATUS);
        rd_check(CSR_MEPC);
        push("rst_redirect_drop", 64'd0);
        push("rst_ack_drop", 64'd0);
        push("rst_mepc_clear", 64'h0);
        push("rst_mstatus_again", 64'h1808);
        reset = 1'b1;
        #1;
        pop_check(64'(redirect));
        pop_check(64'(irq_ack));
        rd_check(CSR_MEPC);
        rd_check(CSR_MSTATUS);
        irq_req = '0;
        tick();
        reset = 1'b0;
        tick();

        total++;
        assert (sb.size() === 0)
        else begin
            bad++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
